// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encoding, default width
// and the counter-width helper.
package mul_pkg;

  localparam int MUL_L = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add step: conditionally add the multiplicand into the
// accumulator, then shift multiplicand left and multiplier right.
module mul_step
  import mul_pkg::*;
#(
  parameter int L = MUL_L
) (
  input  logic [2*L-1:0] acc_i,
  input  logic [2*L-1:0] mcand_i,
  input  logic [L-1:0]   mplier_i,
  output logic [2*L-1:0] acc_o,
  output logic [2*L-1:0] mcand_o,
  output logic [L-1:0]   mplier_o
);

  // The accumulator is 2L wide, so the sum of all partial products never wraps.
  assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
  assign mcand_o  = mcand_i << 1;
  assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned L x L multiplier, one shift-add step per clock.
// Optional MUL_EARLY_EXIT_EN leaves RUN as soon as the multiplier runs out of ones.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int L = MUL_L
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         InValid,
  output logic         InReady,
  input  logic [L-1:0] A,
  input  logic [L-1:0] B,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [L-1:0] R1,
  output logic         Overflow,
  output logic [1:0]   DbgState
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. OutValid, once raised, holds with stable data until taken;
  // InValid is only looked at while InReady is high.

  localparam int              CW       = clog2(L);
  localparam logic [CW-1:0]   CNT_LAST = CW'(L - 1);

  state_e         state_q;
  logic [2*L-1:0] acc_q, mcand_q;
  logic [L-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic [L-1:0]   r1_q;
  logic           ovf_q;
  logic           out_valid_q;

  logic [2*L-1:0] acc_d, mcand_d;
  logic [L-1:0]   mplier_d;
  logic           last_step_d;

  mul_step #(.L(L)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_d),
    .mcand_o  (mcand_d),
    .mplier_o (mplier_d)
  );

  always_comb begin
    last_step_d = 1'b0;
`ifdef MUL_EARLY_EXIT_EN
    last_step_d = (cnt_q == CNT_LAST) || (mplier_d == '0);
`else
    last_step_d = (cnt_q == CNT_LAST);
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      r1_q        <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (InValid) begin
            mcand_q  <= {{L{1'b0}}, A};
            mplier_q <= B;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_step_d) begin
            r1_q        <= acc_d[L-1:0];
            ovf_q       <= |acc_d[2*L-1:L];
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Returning to IDLE never also accepts operands on the same edge.
          if (OutReady) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign InReady  = Rst_n & (state_q == ST_IDLE);
  assign OutValid = out_valid_q;
  assign R1       = r1_q;
  assign Overflow = ovf_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and random bench for mul_sequencer with an expected-result queue.
module tb_mul_sequencer;

  localparam int L = 16;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [L-1:0] A = '0;
  logic [L-1:0] B = '0;
  logic         OutValid;
  logic         OutReady = 1'b0;
  logic [L-1:0] R1;
  logic         Overflow;
  logic [1:0]   DbgState;

  mul_sequencer #(.L(L)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .R1       (R1),
    .Overflow (Overflow),
    .DbgState (DbgState)
  );

  // Clock and cycle counter
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard: {R1, Overflow} and expected latency per issued operation
  logic [L:0] exp_q[$];
  int         lat_q[$];
  int         checks = 0;
  int         errors = 0;
  int         acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [L-1:0] b);
    int n;
    n = L;
`ifdef MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < L; i++) begin
      if (b[i]) n = i + 1;
    end
`endif
    return n;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after accept.
  task automatic issue(input logic [L-1:0] a, input logic [L-1:0] b, input bit push);
    logic [2*L-1:0] full;
    chk("in_ready_before_issue", 32'(InReady), 32'd1);
    InValid = 1'b1;
    A       = a;
    B       = b;
    @(negedge Clk);
    InValid = 1'b0;
    A       = L'($urandom);
    B       = L'($urandom);
    acc_cyc = cyc;
    full = {{L{1'b0}}, a} * {{L{1'b0}}, b};
    if (push) begin
      exp_q.push_back({full[L-1:0], |full[2*L-1:L]});
      lat_q.push_back(exp_lat(b));
    end
  endtask

  // Waits for the result, checks it, optionally backpressures with new operands, then takes it.
  task automatic collect(input int hold, input logic [L-1:0] na, input logic [L-1:0] nb);
    logic [L:0] e;
    int         lat;
    int         waited;
    e      = exp_q.pop_front();
    lat    = lat_q.pop_front();
    waited = 0;
    while (!OutValid && waited < 100) begin
      @(negedge Clk);
      waited++;
    end
    chk("out_valid_seen", 32'(OutValid), 32'd1);
    if (!OutValid) return;
    chk("latency", 32'(cyc - acc_cyc), 32'(lat));
    chk("r1", 32'(R1), 32'(e[L:1]));
    chk("overflow", 32'(Overflow), 32'(e[0]));
    chk("state_done", 32'(DbgState), 32'd2);
    for (int i = 0; i < hold; i++) begin
      InValid = 1'b1;
      A       = na;
      B       = nb;
      @(negedge Clk);
      chk("bp_out_valid", 32'(OutValid), 32'd1);
      chk("bp_r1", 32'(R1), 32'(e[L:1]));
      chk("bp_overflow", 32'(Overflow), 32'(e[0]));
      chk("bp_in_ready", 32'(InReady), 32'd0);
    end
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;
    chk("after_take_out_valid", 32'(OutValid), 32'd0);
    chk("after_take_in_ready", 32'(InReady), 32'd1);
    chk("after_take_r1_held", 32'(R1), 32'(e[L:1]));
    chk("after_take_ovf_held", 32'(Overflow), 32'(e[0]));
  endtask

  initial begin : stim
    logic [L-1:0] ra, rb, na, nb;

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_in_ready", 32'(InReady), 32'd0);
    chk("rst_out_valid", 32'(OutValid), 32'd0);
    chk("rst_r1", 32'(R1), 32'd0);
    chk("rst_overflow", 32'(Overflow), 32'd0);
    chk("rst_state", 32'(DbgState), 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Directed products
    issue(16'd3, 16'd5, 1'b1);
    collect(0, '0, '0);
    issue(16'h0100, 16'h0100, 1'b1);
    collect(0, '0, '0);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    collect(0, '0, '0);
    issue(16'h00FF, 16'h0101, 1'b1);
    collect(0, '0, '0);

    // Backpressure with new operands waiting; they are accepted on the edge after the take
    issue(16'd7, 16'd9, 1'b1);
    collect(5, 16'hABCD, 16'h0003);
    issue(16'hABCD, 16'h0003, 1'b1);
    collect(0, '0, '0);

    // Zero multiplier
    issue(16'h1234, 16'h0000, 1'b1);
    collect(0, '0, '0);

    // Random operands with varied multiplier lengths and backpressure
    ra = L'($urandom);
    rb = L'($urandom_range(0, 65535) >> $urandom_range(0, 15));
    for (int i = 0; i < 8; i++) begin
      na = L'($urandom);
      nb = L'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      issue(ra, rb, 1'b1);
      collect($urandom_range(0, 2), na, nb);
      ra = na;
      rb = nb;
    end

    // Reset in the middle of RUN discards the operation
    issue(16'd3, 16'd5, 1'b0);
    repeat (3) @(negedge Clk);
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(OutValid), 32'd0);
    chk("midrst_r1", 32'(R1), 32'd0);
    chk("midrst_overflow", 32'(Overflow), 32'd0);
    chk("midrst_in_ready", 32'(InReady), 32'd0);
    chk("midrst_state", 32'(DbgState), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("postrst_in_ready", 32'(InReady), 32'd1);
    chk("postrst_out_valid", 32'(OutValid), 32'd0);

    // Machine is usable after the reset
    issue(16'h0011, 16'h0011, 1'b1);
    collect(0, '0, '0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
